regfile_write_scheduler: RTL and testbench

- Single-write-port scheduler in front of RegisterFile; owns RF inputs in, Pcin, RSLCT, LOAD, LOADPC, IR_CU.
- Arbitrates destination writes from the ALU writeback and the memory-load writeback, and handles PC update and increment.
- Passes decoder read selects (Rn/Rm/Rs) through to RSLCT and flags read-after-write hazards against buffered loads.

---
 rtl/regfile_write_scheduler_pkg.sv | 16 +
 rtl/regfile_write_scheduler_if.sv | 50 +++++
 rtl/regfile_write_scheduler_ld_fifo.sv | 68 ++++++
 rtl/regfile_write_scheduler.sv | 179 +++++++++++++++++
 tb/tb_regfile_write_scheduler.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_scheduler_pkg.sv
// Shared constants for the register-file write scheduler: default widths, PC register index/step, RSLCT field layout.
// No logic and no flow control; imported by the scheduler, its load buffer, and the interface.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int AW_DEF     = 4;

  localparam logic [3:0] PC_IDX  = 4'd15;
  localparam int         PC_STEP = 4;

  localparam int RSLCT_W      = 20;
  localparam int RSLCT_FW     = 4;
  localparam int RSLCT_RD_LSB = 16;
  localparam int RSLCT_RN_LSB = 12;
  localparam int RSLCT_RM_LSB = 8;
  localparam int RSLCT_RS_LSB = 4;
endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Write-scheduler bundle: ALU/load writeback in, decoder read selects in, RegisterFile controls out.
// No latency of its own; the load leg is valid/ready, the ALU leg only has the advisory alu_hold.
interface regfile_write_scheduler_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = AW_DEF
) ();
  logic              alu_wr_valid;
  logic [AW-1:0]     alu_wr_addr;
  logic [DATA_W-1:0] alu_wr_data;
  logic              alu_hold;

  logic              ld_wr_valid;
  logic              ld_wr_ready;
  logic [AW-1:0]     ld_wr_addr;
  logic [DATA_W-1:0] ld_wr_data;

  logic              pc_inc;
  logic [DATA_W-1:0] pc_cur;

  logic [AW-1:0]     rd_rn;
  logic [AW-1:0]     rd_rm;
  logic [AW-1:0]     rd_rs;
  logic              hazard;

  logic [DATA_W-1:0]  rf_in;
  logic [DATA_W-1:0]  rf_pcin;
  logic [RSLCT_W-1:0] rf_rslct;
  logic               rf_load;
  logic               rf_loadpc;
  logic               rf_ir_cu;
  logic               err_alu_ovr;

  modport slave (
    input  alu_wr_valid, alu_wr_addr, alu_wr_data,
    input  ld_wr_valid, ld_wr_addr, ld_wr_data,
    input  pc_inc, pc_cur, rd_rn, rd_rm, rd_rs,
    output alu_hold, ld_wr_ready, hazard,
    output rf_in, rf_pcin, rf_rslct, rf_load, rf_loadpc, rf_ir_cu, err_alu_ovr
  );

  modport master (
    output alu_wr_valid, alu_wr_addr, alu_wr_data,
    output ld_wr_valid, ld_wr_addr, ld_wr_data,
    output pc_inc, pc_cur, rd_rn, rd_rm, rd_rs,
    input  alu_hold, ld_wr_ready, hazard,
    input  rf_in, rf_pcin, rf_rslct, rf_load, rf_loadpc, rf_ir_cu, err_alu_ovr
  );
endinterface

// File: rtl/regfile_write_scheduler_ld_fifo.sv
// Load-writeback buffer: DEPTH-entry FIFO, head visible combinationally, push lands next cycle.
// The caller qualifies push with its own ready (!full | pop); every slot's addr/valid is exposed for hazard checks.
module regfile_ld_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = AW_DEF,
  parameter int DW    = DATA_W_DEF
) (
  input  logic                       Clk,
  input  logic                       RESET,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [AW-1:0]              head_addr,
  output logic [DW-1:0]              head_data,
  output logic [DEPTH-1:0]           ent_vld,
  output logic [DEPTH-1:0][AW-1:0]   ent_addr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]            wptr_q, rptr_q;
  logic [CW-1:0]            cnt_q;
  logic [DEPTH-1:0]         vld_q;
  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DW-1:0]            data_q [DEPTH];
  logic                     pop_ok;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign pop_ok    = pop & ~empty;
  assign head_addr = addr_q[rptr_q];
  assign head_data = data_q[rptr_q];
  assign ent_vld   = vld_q;
  assign ent_addr  = addr_q;

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      addr_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      // Pop clears before push sets, so a full-buffer push+pop on the same slot keeps it valid.
      if (pop_ok) begin
        vld_q[rptr_q] <= 1'b0;
        rptr_q        <= rptr_q + PW'(1);
      end
      if (push) begin
        vld_q[wptr_q]  <= 1'b1;
        addr_q[wptr_q] <= push_addr;
        data_q[wptr_q] <= push_data;
        wptr_q         <= wptr_q + PW'(1);
      end
      case ({push, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/regfile_write_scheduler.sv
// Single-write-port scheduler for the RegisterFile: ALU vs buffered-load arbitration, PC update, RAW hazard flag.
// Writes reach the RF one cycle after winning; ALU is never stalled (alu_hold is advisory). Optional REGFILE_SCHED_PERF_EN adds perf counters.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int AW           = AW_DEF,
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic Clk,
  input  logic RESET,
  regfile_write_scheduler_if.slave bus
`ifdef REGFILE_SCHED_PERF_EN
  ,
  output logic [15:0] perf_ldfull_cnt,
  output logic [15:0] perf_hazard_cnt
`endif
);
  localparam int            SW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW-1:0] PC_ADDR = AW'(PC_IDX);

  logic                         fifo_full, fifo_empty;
  logic [AW-1:0]                head_addr;
  logic [DATA_W-1:0]            head_data;
  logic [LQ_DEPTH-1:0]          ent_vld;
  logic [LQ_DEPTH-1:0][AW-1:0]  ent_addr;

  logic                force_ld, alu_win, pop, push, ld_rdy, win_vld, win_is_pc;
  logic [AW-1:0]       win_addr;
  logic [DATA_W-1:0]   win_data;
  logic                hazard;

  logic [SW-1:0]       starve_q, starve_d;
  logic                alu_hold_q, alu_hold_d;
  logic                err_q, err_d;
  logic                rf_load_q, rf_load_d;
  logic                rf_loadpc_q, rf_loadpc_d;
  logic [DATA_W-1:0]   rf_in_q, rf_in_d;
  logic [DATA_W-1:0]   rf_pcin_q, rf_pcin_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [RSLCT_W-1:0]  rslct;

  regfile_ld_fifo #(.DEPTH(LQ_DEPTH), .AW(AW), .DW(DATA_W)) u_ld_fifo (
    .Clk       (Clk),
    .RESET     (RESET),
    .push      (push),
    .push_addr (bus.ld_wr_addr),
    .push_data (bus.ld_wr_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_addr (head_addr),
    .head_data (head_data),
    .ent_vld   (ent_vld),
    .ent_addr  (ent_addr)
  );

  // A hold the ALU ignored is enforced here: the buffer head takes the port anyway.
  assign force_ld  = alu_hold_q & ~fifo_empty;
  assign alu_win   = bus.alu_wr_valid & ~force_ld;
  assign pop       = ~fifo_empty & (force_ld | ~bus.alu_wr_valid);
  assign win_vld   = alu_win | pop;
  assign win_addr  = alu_win ? bus.alu_wr_addr : head_addr;
  assign win_data  = alu_win ? bus.alu_wr_data : head_data;
  assign win_is_pc = win_vld & (win_addr == PC_ADDR);
  assign ld_rdy    = ~fifo_full | pop;
  assign push      = bus.ld_wr_valid & ld_rdy;

  always_comb begin
    starve_d   = starve_q;
    alu_hold_d = 1'b0;
    err_d      = err_q | (force_ld & bus.alu_wr_valid);
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (alu_win) begin
      alu_hold_d = (starve_q == SW'(STARVE_LIMIT - 1));
      if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
    end
  end

  always_comb begin
    rf_load_d   = 1'b0;
    rf_loadpc_d = 1'b0;
    rf_in_d     = rf_in_q;
    rf_pcin_d   = rf_pcin_q;
    rd_d        = rd_q;
    if (win_vld) begin
      rd_d = win_addr;
      if (win_is_pc) begin
        rf_loadpc_d = 1'b1;
        rf_pcin_d   = win_data;
      end else begin
        rf_load_d = 1'b1;
        rf_in_d   = win_data;
      end
    end
    // An explicit R15 write supersedes the sequential increment.
    if (bus.pc_inc && !win_is_pc) begin
      rf_loadpc_d = 1'b1;
      rf_pcin_d   = bus.pc_cur + DATA_W'(PC_STEP);
    end
  end

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      starve_q    <= '0;
      alu_hold_q  <= 1'b0;
      err_q       <= 1'b0;
      rf_load_q   <= 1'b0;
      rf_loadpc_q <= 1'b0;
      rf_in_q     <= '0;
      rf_pcin_q   <= '0;
      rd_q        <= '0;
    end else begin
      starve_q    <= starve_d;
      alu_hold_q  <= alu_hold_d;
      err_q       <= err_d;
      rf_load_q   <= rf_load_d;
      rf_loadpc_q <= rf_loadpc_d;
      rf_in_q     <= rf_in_d;
      rf_pcin_q   <= rf_pcin_d;
      rd_q        <= rd_d;
    end
  end

  function automatic logic sel_hit(input logic [AW-1:0] a, input logic [AW-1:0] rn,
                                   input logic [AW-1:0] rm, input logic [AW-1:0] rs);
    return (a == rn) || (a == rm) || (a == rs);
  endfunction

  // The registered write is still in flight to the RF, so it counts as a hazard too.
  always_comb begin
    hazard = rf_load_q && sel_hit(rd_q, bus.rd_rn, bus.rd_rm, bus.rd_rs);
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (ent_vld[i] && (ent_addr[i] != PC_ADDR) &&
          sel_hit(ent_addr[i], bus.rd_rn, bus.rd_rm, bus.rd_rs))
        hazard = 1'b1;
    end
  end

  always_comb begin
    rslct = '0;
    rslct[RSLCT_RD_LSB +: RSLCT_FW] = RSLCT_FW'(rd_q);
    rslct[RSLCT_RN_LSB +: RSLCT_FW] = RSLCT_FW'(bus.rd_rn);
    rslct[RSLCT_RM_LSB +: RSLCT_FW] = RSLCT_FW'(bus.rd_rm);
    rslct[RSLCT_RS_LSB +: RSLCT_FW] = RSLCT_FW'(bus.rd_rs);
  end

  assign bus.alu_hold    = alu_hold_q;
  assign bus.ld_wr_ready = ld_rdy;
  assign bus.hazard      = hazard;
  assign bus.rf_in       = rf_in_q;
  assign bus.rf_pcin     = rf_pcin_q;
  assign bus.rf_rslct    = rslct;
  assign bus.rf_load     = rf_load_q;
  assign bus.rf_loadpc   = rf_loadpc_q;
  assign bus.rf_ir_cu    = 1'b1;
  assign bus.err_alu_ovr = err_q;

`ifdef REGFILE_SCHED_PERF_EN
  logic [15:0] perf_ldfull_q, perf_hazard_q;

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      perf_ldfull_q <= '0;
      perf_hazard_q <= '0;
    end else begin
      if (bus.ld_wr_valid && !ld_rdy && perf_ldfull_q != 16'hFFFF)
        perf_ldfull_q <= perf_ldfull_q + 16'd1;
      if (hazard && perf_hazard_q != 16'hFFFF)
        perf_hazard_q <= perf_hazard_q + 16'd1;
    end
  end

  assign perf_ldfull_cnt = perf_ldfull_q;
  assign perf_hazard_cnt = perf_hazard_q;
`endif
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: hand-computed vectors per scenario, inline checks, one summary line.
module tb_regfile_write_scheduler;
  import regfile_pkg::*;

  logic Clk;
  logic RESET;
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  regfile_write_scheduler_if bus ();

`ifdef REGFILE_SCHED_PERF_EN
  logic [15:0] perf_ldfull_cnt, perf_hazard_cnt;
`endif

  regfile_write_scheduler dut (
    .Clk   (Clk),
    .RESET (RESET),
    .bus   (bus)
`ifdef REGFILE_SCHED_PERF_EN
    ,
    .perf_ldfull_cnt (perf_ldfull_cnt),
    .perf_hazard_cnt (perf_hazard_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_wr_valid = 1'b0; bus.alu_wr_addr = '0; bus.alu_wr_data = '0;
    bus.ld_wr_valid  = 1'b0; bus.ld_wr_addr  = '0; bus.ld_wr_data  = '0;
    bus.pc_inc = 1'b0; bus.pc_cur = '0;
    bus.rd_rn = '0; bus.rd_rm = '0; bus.rd_rs = '0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    idle_inputs();
    repeat (2) @(posedge Clk);
    #1;
    vec_cnt++; if (bus.rf_load !== 1'b0) begin miss_cnt++; $display("FAIL rst_load: got %b want 0", bus.rf_load); end
    vec_cnt++; if (bus.rf_loadpc !== 1'b0) begin miss_cnt++; $display("FAIL rst_loadpc: got %b want 0", bus.rf_loadpc); end
    vec_cnt++; if (bus.ld_wr_ready !== 1'b1) begin miss_cnt++; $display("FAIL rst_ready: got %b want 1", bus.ld_wr_ready); end
    vec_cnt++; if (bus.rf_ir_cu !== 1'b1) begin miss_cnt++; $display("FAIL rst_ir_cu: got %b want 1", bus.rf_ir_cu); end
    vec_cnt++; if (bus.alu_hold !== 1'b0) begin miss_cnt++; $display("FAIL rst_hold: got %b want 0", bus.alu_hold); end
    vec_cnt++; if (bus.err_alu_ovr !== 1'b0) begin miss_cnt++; $display("FAIL rst_err: got %b want 0", bus.err_alu_ovr); end
    vec_cnt++; if (bus.rf_in !== 32'h0 || bus.rf_pcin !== 32'h0) begin miss_cnt++; $display("FAIL rst_data: got in=%h pcin=%h want 0/0", bus.rf_in, bus.rf_pcin); end
    vec_cnt++; if (bus.hazard !== 1'b0) begin miss_cnt++; $display("FAIL rst_hazard: got %b want 0", bus.hazard); end
    RESET = 1'b1;
  endtask

  task automatic test_alu_write();
    cyc();
    bus.alu_wr_valid = 1'b1; bus.alu_wr_addr = 4'd3; bus.alu_wr_data = 32'h11;
    bus.rd_rn = 4'd1; bus.rd_rm = 4'd2; bus.rd_rs = 4'hA;
    #1;
    vec_cnt++; if (bus.rf_rslct !== 20'h012A0) begin miss_cnt++; $display("FAIL rslct_pass: got %h want 012a0", bus.rf_rslct); end
    vec_cnt++; if (bus.ld_wr_ready !== 1'b1) begin miss_cnt++; $display("FAIL alu_ready: got %b want 1", bus.ld_wr_ready); end
    cyc();
    bus.alu_wr_valid = 1'b0;
    vec_cnt++; if (bus.rf_load !== 1'b1 || bus.rf_loadpc !== 1'b0) begin miss_cnt++; $display("FAIL alu_strobe: got load=%b loadpc=%b want 1/0", bus.rf_load, bus.rf_loadpc); end
    vec_cnt++; if (bus.rf_rslct !== 20'h312A0) begin miss_cnt++; $display("FAIL alu_rslct: got %h want 312a0", bus.rf_rslct); end
    vec_cnt++; if (bus.rf_in !== 32'h11) begin miss_cnt++; $display("FAIL alu_data: got %h want 11", bus.rf_in); end
    bus.rd_rn = '0; bus.rd_rm = '0; bus.rd_rs = '0;
    cyc();
    vec_cnt++; if (bus.rf_load !== 1'b0) begin miss_cnt++; $display("FAIL alu_idle: got %b want 0", bus.rf_load); end
  endtask

  task automatic test_starve();
    cyc();
    bus.alu_wr_valid = 1'b1; bus.alu_wr_addr = 4'd1; bus.alu_wr_data = 32'hA1;
    bus.ld_wr_valid = 1'b1; bus.ld_wr_addr = 4'd5; bus.ld_wr_data = 32'h55;
    cyc();
    bus.alu_wr_addr = 4'd2; bus.ld_wr_addr = 4'd6; bus.ld_wr_data = 32'h66;
    #1;
    vec_cnt++; if (bus.ld_wr_ready !== 1'b1) begin miss_cnt++; $display("FAIL st_ready1: got %b want 1", bus.ld_wr_ready); end
    cyc();
    bus.alu_wr_addr = 4'd3; bus.ld_wr_addr = 4'd8; bus.ld_wr_data = 32'h88;
    #1;
    vec_cnt++; if (bus.ld_wr_ready !== 1'b0) begin miss_cnt++; $display("FAIL st_full: got %b want 0", bus.ld_wr_ready); end
    cyc();
    bus.ld_wr_valid = 1'b0; bus.alu_wr_addr = 4'd4;
    cyc();
    vec_cnt++; if (bus.alu_hold !== 1'b0) begin miss_cnt++; $display("FAIL st_hold_early: got %b want 0", bus.alu_hold); end
    cyc();
    vec_cnt++; if (bus.alu_hold !== 1'b1) begin miss_cnt++; $display("FAIL st_hold: got %b want 1", bus.alu_hold); end
    bus.alu_wr_valid = 1'b0;
    #1;
    vec_cnt++; if (bus.ld_wr_ready !== 1'b1) begin miss_cnt++; $display("FAIL st_ready_pop: got %b want 1", bus.ld_wr_ready); end
    cyc();
    vec_cnt++; if (bus.alu_hold !== 1'b0) begin miss_cnt++; $display("FAIL st_hold_pulse: got %b want 0", bus.alu_hold); end
    vec_cnt++; if (bus.rf_load !== 1'b1 || bus.rf_rslct[19:16] !== 4'd5 || bus.rf_in !== 32'h55) begin miss_cnt++; $display("FAIL st_r5: got load=%b rd=%h in=%h want 1/5/55", bus.rf_load, bus.rf_rslct[19:16], bus.rf_in); end
    cyc();
    vec_cnt++; if (bus.rf_load !== 1'b1 || bus.rf_rslct[19:16] !== 4'd6 || bus.rf_in !== 32'h66) begin miss_cnt++; $display("FAIL st_r6: got load=%b rd=%h in=%h want 1/6/66", bus.rf_load, bus.rf_rslct[19:16], bus.rf_in); end
    vec_cnt++; if (bus.err_alu_ovr !== 1'b0) begin miss_cnt++; $display("FAIL st_err: got %b want 0", bus.err_alu_ovr); end
    cyc();
    vec_cnt++; if (bus.rf_load !== 1'b0) begin miss_cnt++; $display("FAIL st_drained: got %b want 0", bus.rf_load); end
  endtask

  task automatic test_pc();
    bus.alu_wr_valid = 1'b1; bus.alu_wr_addr = 4'd15; bus.alu_wr_data = 32'h100;
    bus.pc_inc = 1'b1; bus.pc_cur = 32'h40;
    cyc();
    vec_cnt++; if (bus.rf_loadpc !== 1'b1 || bus.rf_pcin !== 32'h100 || bus.rf_load !== 1'b0) begin miss_cnt++; $display("FAIL pc_r15: got loadpc=%b pcin=%h load=%b want 1/100/0", bus.rf_loadpc, bus.rf_pcin, bus.rf_load); end
    bus.alu_wr_valid = 1'b0; bus.pc_cur = 32'hFFFF_FFFC;
    cyc();
    vec_cnt++; if (bus.rf_loadpc !== 1'b1 || bus.rf_pcin !== 32'h0) begin miss_cnt++; $display("FAIL pc_wrap: got loadpc=%b pcin=%h want 1/0", bus.rf_loadpc, bus.rf_pcin); end
    bus.pc_cur = 32'h40;
    cyc();
    vec_cnt++; if (bus.rf_loadpc !== 1'b1 || bus.rf_pcin !== 32'h44 || bus.rf_load !== 1'b0) begin miss_cnt++; $display("FAIL pc_inc: got loadpc=%b pcin=%h load=%b want 1/44/0", bus.rf_loadpc, bus.rf_pcin, bus.rf_load); end
    bus.pc_inc = 1'b0;
    cyc();
    vec_cnt++; if (bus.rf_loadpc !== 1'b0) begin miss_cnt++; $display("FAIL pc_idle: got %b want 0", bus.rf_loadpc); end
  endtask

  task automatic test_hazard();
    bus.ld_wr_valid = 1'b1; bus.ld_wr_addr = 4'd7; bus.ld_wr_data = 32'h77;
    bus.alu_wr_valid = 1'b1; bus.alu_wr_addr = 4'd1; bus.alu_wr_data = 32'h1;
    bus.rd_rm = 4'd7;
    #1;
    vec_cnt++; if (bus.hazard !== 1'b0) begin miss_cnt++; $display("FAIL hz_empty: got %b want 0", bus.hazard); end
    cyc();
    bus.ld_wr_valid = 1'b0;
    #1;
    vec_cnt++; if (bus.hazard !== 1'b1) begin miss_cnt++; $display("FAIL hz_buf: got %b want 1", bus.hazard); end
    cyc();
    bus.alu_wr_valid = 1'b0;
    #1;
    vec_cnt++; if (bus.hazard !== 1'b1) begin miss_cnt++; $display("FAIL hz_pop: got %b want 1", bus.hazard); end
    cyc();
    vec_cnt++; if (bus.rf_load !== 1'b1 || bus.rf_rslct[19:16] !== 4'd7 || bus.hazard !== 1'b1) begin miss_cnt++; $display("FAIL hz_strobe: got load=%b rd=%h hz=%b want 1/7/1", bus.rf_load, bus.rf_rslct[19:16], bus.hazard); end
    cyc();
    vec_cnt++; if (bus.hazard !== 1'b0) begin miss_cnt++; $display("FAIL hz_clear: got %b want 0", bus.hazard); end
    bus.ld_wr_valid = 1'b1; bus.ld_wr_addr = 4'd15; bus.ld_wr_data = 32'h200;
    bus.alu_wr_valid = 1'b1; bus.alu_wr_addr = 4'd2; bus.rd_rm = 4'd15;
    cyc();
    bus.ld_wr_valid = 1'b0;
    #1;
    vec_cnt++; if (bus.hazard !== 1'b0) begin miss_cnt++; $display("FAIL hz_r15: got %b want 0", bus.hazard); end
    cyc();
    bus.alu_wr_valid = 1'b0;
    cyc();
    vec_cnt++; if (bus.rf_loadpc !== 1'b1 || bus.rf_pcin !== 32'h200 || bus.rf_load !== 1'b0) begin miss_cnt++; $display("FAIL hz_r15_wr: got loadpc=%b pcin=%h load=%b want 1/200/0", bus.rf_loadpc, bus.rf_pcin, bus.rf_load); end
    bus.rd_rm = '0;
  endtask

  task automatic test_override();
    cyc();
    bus.alu_wr_valid = 1'b1; bus.alu_wr_addr = 4'd1; bus.alu_wr_data = 32'h1;
    bus.ld_wr_valid = 1'b1; bus.ld_wr_addr = 4'd9; bus.ld_wr_data = 32'h99;
    cyc();
    bus.ld_wr_valid = 1'b0;
    repeat (4) cyc();
    vec_cnt++; if (bus.alu_hold !== 1'b1) begin miss_cnt++; $display("FAIL ov_hold: got %b want 1", bus.alu_hold); end
    bus.alu_wr_addr = 4'd2; bus.alu_wr_data = 32'h22;
    cyc();
    bus.alu_wr_valid = 1'b0;
    vec_cnt++; if (bus.rf_load !== 1'b1 || bus.rf_rslct[19:16] !== 4'd9 || bus.rf_in !== 32'h99) begin miss_cnt++; $display("FAIL ov_head: got load=%b rd=%h in=%h want 1/9/99", bus.rf_load, bus.rf_rslct[19:16], bus.rf_in); end
    vec_cnt++; if (bus.err_alu_ovr !== 1'b1) begin miss_cnt++; $display("FAIL ov_err: got %b want 1", bus.err_alu_ovr); end
    cyc();
    vec_cnt++; if (bus.err_alu_ovr !== 1'b1 || bus.rf_load !== 1'b0) begin miss_cnt++; $display("FAIL ov_sticky: got err=%b load=%b want 1/0", bus.err_alu_ovr, bus.rf_load); end
    RESET = 1'b0;
    #2;
    vec_cnt++; if (bus.err_alu_ovr !== 1'b0) begin miss_cnt++; $display("FAIL ov_err_rst: got %b want 0", bus.err_alu_ovr); end
    RESET = 1'b1;
  endtask

  task automatic test_reset_mid();
    cyc();
    bus.alu_wr_valid = 1'b1; bus.alu_wr_addr = 4'd1; bus.alu_wr_data = 32'h1;
    bus.ld_wr_valid = 1'b1; bus.ld_wr_addr = 4'd4; bus.ld_wr_data = 32'h44;
    bus.rd_rn = 4'd4;
    cyc();
    bus.ld_wr_valid = 1'b0;
    #1;
    vec_cnt++; if (bus.hazard !== 1'b1) begin miss_cnt++; $display("FAIL rm_buffered: got %b want 1", bus.hazard); end
    RESET = 1'b0;
    bus.alu_wr_valid = 1'b0;
    #2;
    vec_cnt++; if (bus.hazard !== 1'b0 || bus.ld_wr_ready !== 1'b1 || bus.rf_load !== 1'b0) begin miss_cnt++; $display("FAIL rm_reset: got hz=%b rdy=%b load=%b want 0/1/0", bus.hazard, bus.ld_wr_ready, bus.rf_load); end
    RESET = 1'b1;
    cyc();
    vec_cnt++; if (bus.rf_load !== 1'b0 || bus.hazard !== 1'b0) begin miss_cnt++; $display("FAIL rm_discard1: got load=%b hz=%b want 0/0", bus.rf_load, bus.hazard); end
    cyc();
    vec_cnt++; if (bus.rf_load !== 1'b0) begin miss_cnt++; $display("FAIL rm_discard2: got %b want 0", bus.rf_load); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_starve();
    test_pc();
    test_hazard();
    test_override();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
